// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, bit positions, decode sentinels and FSM states shared by the 7-seg capture logic.
package seg7_pkg;
  localparam logic [7:0] SS_0 = 8'h03;
  localparam logic [7:0] SS_1 = 8'h9F;
  localparam logic [7:0] SS_2 = 8'h25;
  localparam logic [7:0] SS_3 = 8'h0D;
  localparam logic [7:0] SS_4 = 8'h99;
  localparam logic [7:0] SS_5 = 8'h49;
  localparam logic [7:0] SS_6 = 8'h41;
  localparam logic [7:0] SS_7 = 8'h1F;
  localparam logic [7:0] SS_8 = 8'h01;
  localparam logic [7:0] SS_9 = 8'h09;
  localparam logic [7:0] SS_BLANK = 8'hFF;
  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_DP = 0;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR = 4'hE;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps an active-low segment pattern back to BCD, flagging blank and unknown patterns.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);
  logic [7:0] s;
  // dp forced off so it never affects the match
  assign s = seg | (8'h01 << SEG_DP);
  always_comb begin
    bcd = DIG_ERR;
    case (s)
      SS_0:     bcd = 4'd0;
      SS_1:     bcd = 4'd1;
      SS_2:     bcd = 4'd2;
      SS_3:     bcd = 4'd3;
      SS_4:     bcd = 4'd4;
      SS_5:     bcd = 4'd5;
      SS_6:     bcd = 4'd6;
      SS_7:     bcd = 4'd7;
      SS_8:     bcd = 4'd8;
      SS_9:     bcd = 4'd9;
      SS_BLANK: bcd = DIG_BLANK;
      default:  bcd = DIG_ERR;
    endcase
    blank = bcd == DIG_BLANK;
    err = bcd == DIG_ERR;
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples the scanned anode/segment buses, waits for a stable run,
// decodes the selected digit and reports complete 4-digit frames.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [3:0]  an_in,
  input  logic [7:0]  seg_in,
  output logic [15:0] digit_out,
  output logic [3:0]  dp_out,
  output logic [3:0]  digit_vld,
  output logic        frame_done,
  output logic        pat_err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [11:0] s1, s2;
  logic [CW-1:0] cnt;
  logic [3:0] seen, seen_nxt, low, sel, bcd, val;
  logic stable, hit, one, multi, cap, blank, err;
  state_t state, state_nxt;
  seg7_decode u_dec (.seg(s1[7:0]), .bcd(bcd), .blank(blank), .err(err));
  assign stable = s1 == s2;
  // fires only on the edge where the counter reaches the threshold
  assign hit = stable && cnt == CW'(STABLE_CYCLES - 1);
  assign low = ~s1[11:8];
  assign one = |low && ~|(low & (low - 4'd1));
  assign multi = |low && !one;
  assign cap = hit && one;
  assign sel = cap ? low : 4'b0;
  assign val = err ? DIG_ERR : blank ? DIG_BLANK : bcd;
  assign frame_done = state == DONE;
  always_comb begin
    seen_nxt = (state == DONE ? 4'b0 : seen) | sel;
    state_nxt = state == DONE ? COLLECT : seen_nxt == 4'hF ? DONE : cap ? COLLECT : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      cnt <= '0;
      seen <= '0;
      state <= IDLE;
      digit_out <= 16'hFFFF;
      dp_out <= '0;
      digit_vld <= '0;
      pat_err <= 1'b0;
    end else begin
      s1 <= {an_in, seg_in};
      s2 <= s1;
      if (clr) begin
        cnt <= '0;
        seen <= '0;
        state <= IDLE;
        digit_out <= 16'hFFFF;
        dp_out <= '0;
        digit_vld <= '0;
        pat_err <= 1'b0;
      end else begin
        cnt <= !stable ? '0 : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + 1'b1;
        seen <= seen_nxt;
        state <= state_nxt;
        pat_err <= pat_err | (hit && (multi || (one && err)));
        for (int k = 0; k < 4; k++)
          if (sel[k]) begin
            digit_out[4*k +: 4] <= val;
            dp_out[k] <= ~s1[SEG_DP];
            digit_vld[k] <= 1'b1;
          end
      end
    end
  end
endmodule
